// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin share of one multi-cycle MUL/DIV/REM unit
// among NUM_REQ requesters, with a single op in flight and a WAIT timeout.
// Ports:
//   clk, rst                async active-high reset
//   req_valid/req_ready     per-requester accept handshake (ready one-hot)
//   req_op1/op2/funct3      flattened operands, requester i at slice i
//   rsp_valid/result/err    one-cycle response to the owner, err=timeout
//   unit_start/op1/op2/f3   start pulse and held operands to shared unit
//   unit_done/unit_result   completion pulse and data from shared unit
module muldiv_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] req_op2,
  input  logic [NUM_REQ*3-1:0]     req_funct3,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     unit_start,
  output logic [WIDTH-1:0]         unit_op1,
  output logic [WIDTH-1:0]         unit_op2,
  output logic [2:0]               unit_funct3,
  input  logic                     unit_done,
  input  logic [WIDTH-1:0]         unit_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic [2:0]         f3_q, f3_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  int                 j;

  // Scan starts just after the last granted requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    j         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j    = (int'(last_q) + i) % NUM_REQ;
      cand = IDX_W'(j);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    f3_d    = f3_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          op1_d   = req_op1[int'(win_idx)*WIDTH +: WIDTH];
          op2_d   = req_op2[int'(win_idx)*3*0 + int'(win_idx)*WIDTH +: WIDTH];
          f3_d    = req_funct3[int'(win_idx)*3 +: 3];
          owner_d = win_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over an expiring counter.
        if (unit_done) begin
          res_d   = unit_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          res_d   = '1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      op1_q   <= '0;
      op2_q   <= '0;
      f3_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      f3_q    <= f3_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_err    = 1'b0;
    unit_start = (state_q == S_ISSUE);
    if (state_q == S_IDLE && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid[owner_q] = 1'b1;
      rsp_result         = res_q;
      rsp_err            = err_q;
    end
  end

  assign unit_op1    = op1_q;
  assign unit_op2    = op2_q;
  assign unit_funct3 = f3_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: vector table plus corner sequences for muldiv_arbiter,
// with a behavioural shared unit and a response scoreboard.
module tb_muldiv_arbiter;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_op1;
  logic [N*W-1:0] req_op2;
  logic [N*3-1:0] req_funct3;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           unit_start;
  logic [W-1:0]   unit_op1;
  logic [W-1:0]   unit_op2;
  logic [2:0]     unit_funct3;
  logic           unit_done;
  logic [W-1:0]   unit_result;

  logic           model_done = 1'b0;
  logic           spur_done  = 1'b0;
  logic           spur_issue = 1'b0;
  logic           pending    = 1'b0;
  logic [W-1:0]   unit_res_q = '0;
  int             cd = 0;
  int             unit_lat = 3;

  assign unit_done   = model_done | spur_done;
  assign unit_result = model_done ? unit_res_q : 32'hBAD0BAD0;

  always #5 clk = ~clk;

  muldiv_arbiter #(
    .WIDTH(W),
    .NUM_REQ(N),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op1(req_op1),
    .req_op2(req_op2),
    .req_funct3(req_funct3),
    .rsp_valid(rsp_valid),
    .rsp_result(rsp_result),
    .rsp_err(rsp_err),
    .unit_start(unit_start),
    .unit_op1(unit_op1),
    .unit_op2(unit_op2),
    .unit_funct3(unit_funct3),
    .unit_done(unit_done),
    .unit_result(unit_result)
  );

  typedef struct {
    int         req;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic [2:0] f3;
    int         lat;
    logic [W-1:0] res;
    logic       err;
    int         dly;
  } vec_t;

  typedef struct {
    int         owner;
    logic [W-1:0] res;
    logic       err;
    int         dly;
  } exp_t;

  exp_t   sb[$];
  exp_t   exp_for[N];
  exp_t   cur;
  int     grant_log[$];
  vec_t   vecs[7];
  logic [N-1:0] oh;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int acc_cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int last_acc_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Shared unit: done lat cycles after start (lat=0 never answers).
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      model_done = 1'b0;
      pending    = 1'b0;
    end else begin
      model_done = 1'b0;
      if (pending) begin
        cd--;
        if (cd == 0) begin
          model_done = 1'b1;
          pending    = 1'b0;
        end
      end
      if (unit_start) begin
        start_cyc = cyc;
        chk("start_after_accept", 64'(cyc), 64'(acc_cyc + 1));
        case (unit_funct3)
          3'b100:  unit_res_q = unit_op1 / unit_op2;
          3'b110:  unit_res_q = unit_op1 % unit_op2;
          default: unit_res_q = unit_op1 * unit_op2;
        endcase
        pending = 1'b0;
        if (unit_lat > 0) begin
          pending = 1'b1;
          cd      = unit_lat;
        end
        if (spur_issue) model_done = 1'b1;
      end
    end
  end

  // Monitor: handshake exclusivity, accepts into scoreboard, responses out.
  always @(negedge clk) begin
    if (!rst) begin
      if (unit_start || (|req_ready) || (|rsp_valid)) begin
        chk("exclusive_outputs",
            64'($countones({unit_start, req_ready, rsp_valid})), 64'd1);
        chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          sb.push_back(exp_for[i]);
          grant_log.push_back(i);
          acc_cyc      = cyc;
          last_acc_cyc = cyc;
        end
      end
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid %b expected none",
                   rsp_valid);
        end else begin
          cur = sb.pop_front();
          oh  = '0;
          oh[cur.owner] = 1'b1;
          chk("rsp_owner", 64'(rsp_valid), 64'(oh));
          chk("rsp_result", 64'(rsp_result), 64'(cur.res));
          chk("rsp_err", 64'(rsp_err), 64'(cur.err));
          chk("rsp_latency", 64'(cyc - start_cyc), 64'(cur.dly));
        end
        rsp_cnt++;
        last_rsp_cyc = cyc;
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] o1,
                         input logic [W-1:0] o2, input logic [2:0] f,
                         input logic [W-1:0] res, input logic err,
                         input int dly);
    req_op1[i*W +: W]    = o1;
    req_op2[i*W +: W]    = o2;
    req_funct3[i*3 +: 3] = f;
    exp_for[i].owner     = i;
    exp_for[i].res       = res;
    exp_for[i].err       = err;
    exp_for[i].dly       = dly;
  endtask

  task automatic wait_grants(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= n) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d grants expected %0d",
               grant_log.size(), n);
    end
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (rsp_cnt >= n) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d",
               rsp_cnt, n);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n0;
    int g0;
    @(posedge clk);
    #1;
    unit_lat = v.lat;
    set_req(v.req, v.op1, v.op2, v.f3, v.res, v.err, v.dly);
    n0 = rsp_cnt;
    g0 = grant_log.size();
    req_valid[v.req] = 1'b1;
    wait_grants(g0 + 1);
    @(posedge clk);
    #1;
    req_valid[v.req] = 1'b0;
    wait_rsp(n0 + 1);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    grant_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int g0;
    vecs[0] = '{0, 32'd7,      32'd6, 3'b000, 3, 32'd42,      1'b0, 4};
    vecs[1] = '{1, 32'd100,    32'd7, 3'b100, 2, 32'd14,      1'b0, 3};
    vecs[2] = '{0, 32'd100,    32'd7, 3'b110, 5, 32'd2,       1'b0, 6};
    vecs[3] = '{1, 32'd5,      32'd5, 3'b000, 0, 32'hFFFFFFFF, 1'b1, 8};
    vecs[4] = '{0, 32'h1234,   32'd1, 3'b000, 7, 32'h1234,    1'b0, 8};
    vecs[5] = '{1, 32'd3,      32'd9, 3'b000, 9, 32'hFFFFFFFF, 1'b1, 8};
    vecs[6] = '{1, 32'd12,     32'd1, 3'b000, 1, 32'd12,      1'b0, 2};

    rst        = 1'b1;
    req_valid  = '0;
    req_op1    = '0;
    req_op2    = '0;
    req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_unit_start", 64'(unit_start), 64'd0);
    chk("reset_unit_op1", 64'(unit_op1), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Contention: both requesters held valid from reset.
    apply_reset();
    unit_lat = 2;
    set_req(0, 32'd3, 32'd4, 3'b000, 32'd12, 1'b0, 3);
    set_req(1, 32'd20, 32'd3, 3'b100, 32'd6, 1'b0, 3);
    n0 = rsp_cnt;
    req_valid = 2'b11;
    wait_grants(4);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(n0 + 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("rr_grant_order", 64'(grant_log[k]), 64'(k % 2));

    // Reset while waiting on a silent unit; req0 was the last grant.
    run_vec('{0, 32'd2, 32'd3, 3'b000, 2, 32'd6, 1'b0, 3});
    @(posedge clk);
    #1;
    unit_lat = 0;
    set_req(0, 32'hA5A5, 32'h5A5A, 3'b110, 32'hFFFFFFFF, 1'b1, 8);
    g0 = grant_log.size();
    req_valid[0] = 1'b1;
    wait_grants(g0 + 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_unit_op1", 64'(unit_op1), 64'd0);
    chk("rst_async_unit_op2", 64'(unit_op2), 64'd0);
    chk("rst_async_funct3", 64'(unit_funct3), 64'd0);
    chk("rst_async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_async_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_async_unit_start", 64'(unit_start), 64'd0);
    sb.delete();
    grant_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    unit_lat = 2;
    set_req(0, 32'd8, 32'd8, 3'b000, 32'd64, 1'b0, 3);
    set_req(1, 32'd9, 32'd2, 3'b100, 32'd4, 1'b0, 3);
    n0 = rsp_cnt;
    req_valid = 2'b11;
    wait_grants(1);
    if (grant_log.size() > 0)
      chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(n0 + 1);

    // Spurious done in IDLE, done during ISSUE, valid held through RESP.
    @(posedge clk);
    #1;
    n0 = rsp_cnt;
    g0 = grant_log.size();
    spur_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spurious_idle_no_rsp", 64'(rsp_cnt), 64'(n0));
    chk("spurious_idle_no_grant", 64'(grant_log.size()), 64'(g0));
    spur_issue = 1'b1;
    unit_lat = 4;
    set_req(0, 32'd3, 32'd5, 3'b000, 32'd15, 1'b0, 5);
    req_valid[0] = 1'b1;
    wait_grants(g0 + 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    set_req(1, 32'd9, 32'd9, 3'b000, 32'd81, 1'b0, 5);
    req_valid[1] = 1'b1;
    wait_grants(g0 + 2);
    chk("accept_after_resp", 64'(last_acc_cyc - last_rsp_cyc), 64'd1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_rsp(n0 + 2);
    spur_issue = 1'b0;

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
